// File: rtl/seq_tree_multiplier.sv
// seq_tree_multiplier
//   Iterative WIDTH x WIDTH integer multiplier. Each CALC cycle retires BPC
//   multiplier bits. The BPC partial-product rows and the running accumulator
//   are reduced to a sum/carry pair by a chain of full-adder (3:2) layers.
//   A single carry-propagate add then produces the next accumulator value.
//   Operands arrive on a valid/ready handshake, and so does the product.
//   in_signed selects unsigned or two's-complement operation for each
//   transaction.
//
// Parameters
//   WIDTH     operand width (>= 2)
//   BPC       multiplier bits retired per cycle (divides WIDTH)
//
// Ports
//   clk       clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  operand transfer request
//   in_ready  block can accept operands (combinational from out_ready in DONE)
//   in_x      multiplicand
//   in_y      multiplier
//   in_signed 1 = two's complement operands, 0 = unsigned
//   out_valid product available
//   out_ready consumer accepts product
//   out_p     2*WIDTH-bit product
//   busy      high while calculating

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module seq_tree_multiplier #(
  parameter int WIDTH = 8,
  parameter int BPC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   acc_reg;
  logic [PW-1:0]   x_sh_reg;    // extended multiplicand, pre-shifted to the current row group
  logic [WIDTH-1:0] y_sh_reg;   // multiplier, low BPC bits are the current row group
  logic            signed_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   out_p_reg;

  logic            last_iter;
  logic            neg_cycle;
  logic            inject;
  logic [PW-1:0]   acc_next;

  logic [BPC-1:0][PW-1:0] pp;
  logic [BPC-1:0][PW-1:0] sum_l;
  logic [BPC-1:0][PW-1:0] car_l;

  assign last_iter = (cnt_reg == LAST);
  // The multiplier MSB has negative weight in signed mode. It is always the
  // top row of the final group.
  assign neg_cycle = signed_reg && last_iter;
  // Negating a row means inverting it and adding 1. The +1 enters at the final add.
  assign inject    = neg_cycle && y_sh_reg[BPC-1];

  genvar gi, gb;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_pp
      logic [PW-1:0] sh_w;
      assign sh_w = x_sh_reg << gi;
      if (gi == BPC - 1) begin : g_top
        assign pp[gi] = !y_sh_reg[gi] ? '0 : (neg_cycle ? ~sh_w : sh_w);
      end else begin : g_pos
        assign pp[gi] = y_sh_reg[gi] ? sh_w : '0;
      end
    end

    // Linear 3:2 chain. Layer 0 is the accumulator plus row 0. Each further
    // layer folds in one more row. Carries out of the MSB are dropped because
    // the arithmetic is modulo 2^PW.
    assign sum_l[0] = acc_reg;
    assign car_l[0] = pp[0];
    for (gi = 1; gi < BPC; gi++) begin : g_csa
      logic [PW-2:0] co_w;
      for (gb = 0; gb < PW - 1; gb++) begin : g_bit
        fa_cell u_fa (
          .a   (sum_l[gi-1][gb]),
          .b   (car_l[gi-1][gb]),
          .cin (pp[gi][gb]),
          .sum (sum_l[gi][gb]),
          .cout(co_w[gb])
        );
      end
      assign sum_l[gi][PW-1] = sum_l[gi-1][PW-1] ^ car_l[gi-1][PW-1] ^ pp[gi][PW-1];
      assign car_l[gi] = {co_w, 1'b0};
    end
  endgenerate

  assign acc_next = sum_l[BPC-1] + car_l[BPC-1] + {{(PW-1){1'b0}}, inject};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      x_sh_reg   <= '0;
      y_sh_reg   <= '0;
      signed_reg <= 1'b0;
      cnt_reg    <= '0;
      out_p_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg  <= CALC;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            x_sh_reg   <= {{WIDTH{in_signed & in_x[WIDTH-1]}}, in_x};
            y_sh_reg   <= in_y;
            signed_reg <= in_signed;
          end
        end
        CALC: begin
          acc_reg  <= acc_next;
          x_sh_reg <= x_sh_reg << BPC;
          y_sh_reg <= y_sh_reg >> BPC;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_iter) begin
            out_p_reg <= acc_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              // Back-to-back: accept the next operands in the same edge as the output transfer
              state_reg  <= CALC;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              x_sh_reg   <= {{WIDTH{in_signed & in_x[WIDTH-1]}}, in_x};
              y_sh_reg   <= in_y;
              signed_reg <= in_signed;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC);
  assign out_p     = out_p_reg;

endmodule

// File: tb/tb_seq_tree_multiplier.sv
module tb_seq_tree_multiplier;

  logic clk;
  logic rst_n;

  // Index 0: (8,2)  1: (16,4)  2: (16,1)  3: (8,8)
  logic        iv_a   [4];
  logic        ir_a   [4];
  logic [15:0] x_a    [4];
  logic [15:0] y_a    [4];
  logic        is_a   [4];
  logic        ov_a   [4];
  logic        or_a   [4];
  logic [31:0] p_a    [4];
  logic        busy_a [4];

  logic [15:0] p0_w, p3_w;
  logic [31:0] p1_w, p2_w;

  int n_run;
  int n_fail;

  seq_tree_multiplier #(.WIDTH(8), .BPC(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[0]), .in_ready(ir_a[0]),
    .in_x(x_a[0][7:0]), .in_y(y_a[0][7:0]), .in_signed(is_a[0]),
    .out_valid(ov_a[0]), .out_ready(or_a[0]), .out_p(p0_w), .busy(busy_a[0]));

  seq_tree_multiplier #(.WIDTH(16), .BPC(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[1]), .in_ready(ir_a[1]),
    .in_x(x_a[1]), .in_y(y_a[1]), .in_signed(is_a[1]),
    .out_valid(ov_a[1]), .out_ready(or_a[1]), .out_p(p1_w), .busy(busy_a[1]));

  seq_tree_multiplier #(.WIDTH(16), .BPC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[2]), .in_ready(ir_a[2]),
    .in_x(x_a[2]), .in_y(y_a[2]), .in_signed(is_a[2]),
    .out_valid(ov_a[2]), .out_ready(or_a[2]), .out_p(p2_w), .busy(busy_a[2]));

  seq_tree_multiplier #(.WIDTH(8), .BPC(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a[3]), .in_ready(ir_a[3]),
    .in_x(x_a[3][7:0]), .in_y(y_a[3][7:0]), .in_signed(is_a[3]),
    .out_valid(ov_a[3]), .out_ready(or_a[3]), .out_p(p3_w), .busy(busy_a[3]));

  assign p_a[0] = {16'h0000, p0_w};
  assign p_a[1] = p1_w;
  assign p_a[2] = p2_w;
  assign p_a[3] = {16'h0000, p3_w};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Exact product of the operands read in the selected mode, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input int w);
    longint a, b, m, p;
    m = (64'sd1 <<< w) - 1;
    a = longint'(x) & m;
    b = longint'(y) & m;
    if (s && x[w-1]) a = a - (64'sd1 <<< w);
    if (s && y[w-1]) b = b - (64'sd1 <<< w);
    p = a * b;
    return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  // Full transaction from IDLE. Called at posedge+1. Checks latency, product
  // and the output handshake.
  task automatic do_txn(input int k, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic [31:0] exp, input int lat,
                        input int hold, input string name);
    int cyc;
    x_a[k]  = x;
    y_a[k]  = y;
    is_a[k] = s;
    iv_a[k] = 1'b1;
    chk({name, "_in_ready"}, 32'(ir_a[k]), 32'd1);
    @(posedge clk); #1;
    iv_a[k] = 1'b0;
    x_a[k]  = 16'($urandom);
    y_a[k]  = 16'($urandom);
    is_a[k] = 1'($urandom);
    cyc = 0;
    while (!ov_a[k] && cyc < lat + 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(lat));
    chk({name, "_product"}, p_a[k], exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_p"}, p_a[k], exp);
    end
    or_a[k] = 1'b1;
    @(posedge clk); #1;
    or_a[k] = 1'b0;
    chk({name, "_released"}, 32'(ov_a[k]), 32'd0);
  endtask

  vec_t vecs[8];
  int   lat_a[4];
  int   wid_a[4];

  initial begin
    logic [15:0] rx, ry;
    logic        rs;
    logic [31:0] mask;
    int          cyc;

    n_run  = 0;
    n_fail = 0;
    lat_a = '{4, 4, 16, 1};
    wid_a = '{8, 16, 16, 8};
    vecs[0] = '{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    vecs[1] = '{16'h0080, 16'h0080, 1'b1, 32'h00004000};
    vecs[2] = '{16'h00FF, 16'h007F, 1'b1, 32'h0000FF81};
    vecs[3] = '{16'h0000, 16'h00AB, 1'b0, 32'h00000000};
    vecs[4] = '{16'h00FF, 16'h007F, 1'b0, 32'h00007E81};
    vecs[5] = '{16'h00FF, 16'h00FF, 1'b1, 32'h00000001};
    vecs[6] = '{16'h0080, 16'h007F, 1'b1, 32'h0000C080};
    vecs[7] = '{16'h0080, 16'h0002, 1'b0, 32'h00000100};

    for (int k = 0; k < 4; k++) begin
      iv_a[k] = 1'b0; x_a[k] = '0; y_a[k] = '0; is_a[k] = 1'b0; or_a[k] = 1'b0;
    end

    // Reset state, including a request during reset that must not transfer.
    rst_n = 1'b0;
    iv_a[0] = 1'b1; x_a[0] = 16'h0005; y_a[0] = 16'h0007;
    #12;
    chk("rst_out_valid", 32'(ov_a[0]), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_out_p", p_a[0], 32'd0);
    chk("rst_in_ready", 32'(ir_a[0]), 32'd1);
    @(posedge clk); #1;
    chk("rst_no_transfer", 32'(busy_a[0]), 32'd0);
    iv_a[0] = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++)
      do_txn(0, vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp, 4, i % 3, $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready=0, with the inputs toggling.
    x_a[0] = 16'h0012; y_a[0] = 16'h0034; is_a[0] = 1'b0; iv_a[0] = 1'b1;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    cyc = 0;
    while (!ov_a[0] && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("bp_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 10; i++) begin
      x_a[0] = 16'($urandom); y_a[0] = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(ov_a[0]), 32'd1);
      chk("bp_out_p", p_a[0], 32'h000003A8);
      chk("bp_in_ready", 32'(ir_a[0]), 32'd0);
    end
    or_a[0] = 1'b1;
    @(posedge clk); #1;
    or_a[0] = 1'b0;
    chk("bp_idle_valid", 32'(ov_a[0]), 32'd0);
    chk("bp_idle_busy", 32'(busy_a[0]), 32'd0);
    chk("bp_idle_ready", 32'(ir_a[0]), 32'd1);

    // Back-to-back: 3*5 then 7*9 with no IDLE cycle between them.
    x_a[0] = 16'd3; y_a[0] = 16'd5; is_a[0] = 1'b0; iv_a[0] = 1'b1;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    cyc = 0;
    while (!ov_a[0] && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("b2b_first_p", p_a[0], 32'h0000000F);
    x_a[0] = 16'd7; y_a[0] = 16'd9; iv_a[0] = 1'b1; or_a[0] = 1'b1;
    #1;
    chk("b2b_in_ready_follows", 32'(ir_a[0]), 32'd1);
    @(posedge clk); #1;
    iv_a[0] = 1'b0; or_a[0] = 1'b0;
    chk("b2b_direct_calc", 32'(busy_a[0]), 32'd1);
    chk("b2b_valid_dropped", 32'(ov_a[0]), 32'd0);
    cyc = 0;
    while (!ov_a[0] && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("b2b_latency", 32'(cyc), 32'd4);
    chk("b2b_second_p", p_a[0], 32'h0000003F);
    or_a[0] = 1'b1;
    @(posedge clk); #1;
    or_a[0] = 1'b0;

    // Reset two cycles into CALC.
    x_a[0] = 16'h00AB; y_a[0] = 16'h00CD; is_a[0] = 1'b0; iv_a[0] = 1'b1;
    @(posedge clk); #1;
    iv_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(busy_a[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov_a[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_a[0]), 32'd0);
    chk("mid_rst_p", p_a[0], 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 32'(ov_a[0]), 32'd0);
    end
    do_txn(0, 16'd2, 16'd3, 1'b0, 32'h00000006, 4, 1, "post_rst");

    // Randomized sweep across all four parameter sets against the reference model.
    for (int k = 0; k < 4; k++) begin
      mask = (32'd1 << wid_a[k]) - 32'd1;
      for (int t = 0; t < ((k == 0) ? 200 : 600); t++) begin
        rx = 16'($urandom & mask);
        ry = 16'($urandom & mask);
        if (t < 4) begin
          // Boundary operands: all ones and MSB only
          rx = (t[0]) ? 16'(32'd1 << (wid_a[k] - 1)) : 16'(mask);
          ry = rx;
        end
        rs = (t < 4) ? t[1] : 1'($urandom);
        do_txn(k, rx, ry, rs, ref_mul(rx, ry, rs, wid_a[k]), lat_a[k],
               $urandom_range(0, 3), $sformatf("rnd_k%0d_t%0d", k, t));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
